// File: rtl/pixel_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : pixel_burst_scheduler_if
// Brief  : Source/destination FIFO handshake bundle for pixel_burst_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface pixel_burst_scheduler_if #(
    parameter int FIFO_AW = 10
);
    logic               enable;
    logic [FIFO_AW-1:0] src_count;
    logic               src_rd;
    logic [16:0]        src_data;
    logic [FIFO_AW-1:0] dst_count_w;
    logic               dst_wr;
    logic [16:0]        dst_data;
    logic               locked;
    logic               frame_done;
    logic               sof_error;
    logic               busy;

    modport master (
        output enable, src_count, src_data, dst_count_w,
        input  src_rd, dst_wr, dst_data, locked, frame_done, sof_error, busy
    );

    modport slave (
        input  enable, src_count, src_data, dst_count_w,
        output src_rd, dst_wr, dst_data, locked, frame_done, sof_error, busy
    );
endinterface
`default_nettype wire

// File: rtl/pixel_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module : pixel_burst_scheduler
// Brief  : Moves fixed-length pixel bursts between FIFOs and tracks frame position.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_burst_scheduler #(
    parameter int BURST    = 8,
    parameter int MARGIN   = 4,
    parameter int FIFO_AW  = 10,
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240
) (
    input  wire logic               clk_w,
    input  wire logic               rst_n,
    pixel_burst_scheduler_if.slave  bus
);
    localparam int              c_xw       = $clog2(H_ACTIVE + 1);
    localparam int              c_yw       = $clog2(V_ACTIVE + 1);
    localparam logic [FIFO_AW:0] c_depth   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] c_need    = (FIFO_AW + 1)'(BURST + MARGIN);
    localparam logic [FIFO_AW-1:0] c_burst = FIFO_AW'(BURST);
    localparam logic [6:0]      c_last     = 7'(BURST - 1);
    localparam logic [c_xw-1:0] c_x_last   = c_xw'(H_ACTIVE - 1);
    localparam logic [c_yw-1:0] c_y_last   = c_yw'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [6:0]      cnt_q;
    logic            src_rd_q;
    logic            busy_q;
    logic            rd_q;
    logic            dst_wr_q;
    logic [16:0]     dst_data_q;
    logic            locked_q;
    logic            frame_done_q;
    logic            sof_error_q;
    logic [c_xw-1:0] x_q;
    logic [c_yw-1:0] y_q;

    logic            wr_d;
    logic            locked_d;
    logic            frame_done_d;
    logic            sof_error_d;
    logic [c_xw-1:0] x_d;
    logic [c_yw-1:0] y_d;

    logic [FIFO_AW:0] w_dst_free;
    logic             w_grant;

    // Free space is one bit wider so a completely empty FIFO reports full depth.
    assign w_dst_free = c_depth - {1'b0, bus.dst_count_w};
    assign w_grant    = bus.enable && (bus.src_count >= c_burst) && (w_dst_free >= c_need);

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            src_rd_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_grant) begin
                        state_q  <= S_READ;
                        src_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                S_READ: begin
                    if (cnt_q == c_last) begin
                        state_q  <= S_DRAIN;
                        src_rd_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    src_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Pixel disposition: SOF resync takes priority over raster advance.
    always_comb begin
        wr_d         = 1'b0;
        frame_done_d = 1'b0;
        sof_error_d  = 1'b0;
        locked_d     = locked_q;
        x_d          = x_q;
        y_d          = y_q;
        if (rd_q) begin
            if (bus.src_data[16]) begin
                wr_d        = 1'b1;
                sof_error_d = locked_q && ((x_q != '0) || (y_q != '0));
                locked_d    = 1'b1;
                x_d         = c_xw'(1);
                y_d         = '0;
            end else if (locked_q) begin
                wr_d = 1'b1;
                if (x_q == c_x_last) begin
                    x_d = '0;
                    if (y_q == c_y_last) begin
                        y_d          = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= 1'b0;
            dst_wr_q     <= 1'b0;
            dst_data_q   <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sof_error_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            rd_q         <= src_rd_q;
            dst_wr_q     <= wr_d;
            frame_done_q <= frame_done_d;
            sof_error_q  <= sof_error_d;
            locked_q     <= locked_d;
            x_q          <= x_d;
            y_q          <= y_d;
            if (wr_d) begin
                dst_data_q <= bus.src_data;
            end
        end
    end

    assign bus.src_rd     = src_rd_q;
    assign bus.busy       = busy_q;
    assign bus.dst_wr     = dst_wr_q;
    assign bus.dst_data   = dst_data_q;
    assign bus.locked     = locked_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sof_error  = sof_error_q;
endmodule
`default_nettype wire

// File: tb/tb_pixel_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_pixel_burst_scheduler
// Brief  : Self-checking bench with a pixel-index reference model and random FIFO levels.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixel_burst_scheduler;
    localparam int BURST    = 8;
    localparam int MARGIN   = 4;
    localparam int FIFO_AW  = 10;
    localparam int H_ACTIVE = 128;
    localparam int V_ACTIVE = 8;
    localparam int FRAME    = H_ACTIVE * V_ACTIVE;

    logic clk_w = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_w = ~clk_w;

    pixel_burst_scheduler_if #(.FIFO_AW(FIFO_AW)) bus ();

    pixel_burst_scheduler #(
        .BURST(BURST), .MARGIN(MARGIN), .FIFO_AW(FIFO_AW),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)
    ) dut (
        .clk_w(clk_w),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Source pixel generator: directed prefix queue, then raster frames by linear index.
    logic [16:0] src_q[$];
    int gen_p     = 0;
    int inject_at = -1;

    function automatic logic [16:0] next_pixel();
        logic [16:0] p;
        logic        sof;
        if (src_q.size() > 0) begin
            p = src_q.pop_front();
        end else begin
            sof = (gen_p == 0) || (gen_p == inject_at);
            if (gen_p == inject_at) inject_at = -1;
            gen_p = sof ? 1 : (gen_p + 1) % FRAME;
            p = {sof, 16'($urandom)};
        end
        return p;
    endfunction

    function automatic bit grant_now();
        return bus.enable && (int'(bus.src_count) >= BURST) &&
               (((1 << FIFO_AW) - int'(bus.dst_count_w)) >= BURST + MARGIN);
    endfunction

    // Reference model state: position is a single index into the frame.
    bit          rd_prev;
    bit          exp_wr, exp_fd, exp_se;
    logic [16:0] exp_data;
    bit          lk_m;
    int          pos_m;
    int          run_len, gap;
    int          n_wr = 0, n_fd = 0, n_se = 0;

    always @(negedge clk_w) begin
        logic [16:0] pix;
        if (!rst_n) begin
            rd_prev = 0; exp_wr = 0; exp_fd = 0; exp_se = 0; exp_data = '0;
            lk_m = 0; pos_m = 0; run_len = 0; gap = 2;
            bus.src_data = '0;
            chk("rst_src_rd", bus.src_rd, 0);
            chk("rst_dst_wr", bus.dst_wr, 0);
            chk("rst_locked", bus.locked, 0);
        end else begin
            chk("dst_wr", bus.dst_wr, exp_wr);
            if (exp_wr) chk("dst_data", bus.dst_data, exp_data);
            chk("frame_done", bus.frame_done, exp_fd);
            chk("sof_error", bus.sof_error, exp_se);
            chk("locked", bus.locked, lk_m);
            if (bus.dst_wr)     n_wr++;
            if (bus.frame_done) n_fd++;
            if (bus.sof_error)  n_se++;

            if (bus.src_rd) begin
                if (run_len == 0) begin
                    chk("grant_at_start", grant_now(), 1);
                    chk("idle_gap", gap >= 2, 1);
                end
                run_len++;
                gap = 0;
            end else begin
                if (run_len != 0) chk("burst_len", run_len, BURST);
                run_len = 0;
                gap++;
            end

            exp_wr = 0; exp_fd = 0; exp_se = 0;
            if (rd_prev) begin
                pix = next_pixel();
                bus.src_data = pix;
                exp_data = pix;
                if (pix[16]) begin
                    exp_se = lk_m && (pos_m != 0);
                    lk_m   = 1; pos_m = 1; exp_wr = 1;
                end else if (lk_m) begin
                    pos_m++;
                    if (pos_m == FRAME) begin pos_m = 0; exp_fd = 1; end
                    exp_wr = 1;
                end
            end
            rd_prev = bus.src_rd;
        end
    end

    typedef struct {
        bit en;
        int sc;
        int dc;
        bit start;
    } vec_t;
    vec_t vecs[9];

    task automatic rand_step();
        @(negedge clk_w); #1;
        bus.enable      = ($urandom_range(0, 3) != 0);
        bus.src_count   = FIFO_AW'($urandom_range(0, 40));
        bus.dst_count_w = FIFO_AW'($urandom_range(980, 1023));
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((bus.busy || bus.src_rd) && k < 40) begin
            @(negedge clk_w); #1;
            k++;
        end
        chk(nm, k < 40, 1);
        repeat (3) @(negedge clk_w);
        #1;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int busy_n, rd_n, first_wr, k, w0, f0, s0, w_inj;
        bit started;

        vecs[0] = '{1, 7,    0,    0};
        vecs[1] = '{1, 20,   1013, 0};
        vecs[2] = '{1, 20,   1012, 1};
        vecs[3] = '{1, 8,    1012, 1};
        vecs[4] = '{0, 20,   0,    0};
        vecs[5] = '{1, 1023, 0,    1};
        vecs[6] = '{1, 0,    0,    0};
        vecs[7] = '{1, 8,    1023, 0};
        vecs[8] = '{1, 9,    1011, 1};

        bus.enable = 0; bus.src_count = '0; bus.dst_count_w = '0;
        repeat (3) @(negedge clk_w);
        #1;
        chk("t1_rst_busy", bus.busy, 0);
        chk("t1_rst_dst_data", bus.dst_data, 0);
        chk("t1_rst_fd", bus.frame_done, 0);
        chk("t1_rst_se", bus.sof_error, 0);

        // Test 1: first burst timing right after reset
        bus.enable = 1; bus.src_count = 20; bus.dst_count_w = 0;
        rst_n = 1;
        @(negedge clk_w); #1;
        chk("t1_first_rd", bus.src_rd, 1);
        bus.enable = 0;
        busy_n = 0; rd_n = 0; first_wr = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin @(negedge clk_w); #1; end
            busy_n += int'(bus.busy);
            rd_n   += int'(bus.src_rd);
            if (bus.dst_wr && first_wr < 0) first_wr = i;
        end
        chk("t1_busy_cycles", busy_n, 9);
        chk("t1_rd_cycles", rd_n, BURST);
        chk("t1_first_wr_lat", first_wr, 2);
        chk("t1_locked", bus.locked, 1);

        // Test 2: grant threshold table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_w); #1;
            bus.enable      = vecs[i].en;
            bus.src_count   = FIFO_AW'(vecs[i].sc);
            bus.dst_count_w = FIFO_AW'(vecs[i].dc);
            started = 0;
            repeat (3) begin
                @(negedge clk_w); #1;
                if (bus.src_rd) started = 1;
            end
            chk($sformatf("t2_vec%0d_start", i), started, vecs[i].start);
            bus.enable = 0;
            wait_idle("t2_idle");
        end

        // Test 3: pixels before the first SOF are discarded
        rst_n = 0; bus.enable = 0;
        src_q.delete();
        gen_p = 0; inject_at = -1;
        for (int i = 0; i < 3; i++) src_q.push_back({1'b0, 16'(16'h1110 + i)});
        repeat (2) @(negedge clk_w);
        #1;
        w0 = n_wr;
        bus.enable = 1; bus.src_count = 20; bus.dst_count_w = 0;
        rst_n = 1;
        @(negedge clk_w); #1;
        bus.enable = 0;
        chk("t3_locked_early", bus.locked, 0);
        wait_idle("t3_idle");
        chk("t3_writes", n_wr - w0, BURST - 3);
        chk("t3_locked", bus.locked, 1);

        // Test 4: complete the frame under random FIFO levels
        f0 = n_fd;
        k = 0;
        while (n_fd == f0 && k < 8000) begin rand_step(); k++; end
        chk("t4_timeout", k < 8000, 1);
        chk("t4_frame_writes", n_wr - w0, FRAME);
        chk("t4_frame_done_once", n_fd - f0, 1);

        // Test 5: misplaced SOF at pixel 100 of line 5, then a full frame from it
        inject_at = 5 * H_ACTIVE + 100;
        s0 = n_se; f0 = n_fd;
        k = 0;
        while (n_se == s0 && k < 8000) begin rand_step(); k++; end
        chk("t5_sof_err_timeout", k < 8000, 1);
        chk("t5_sof_err_once", n_se - s0, 1);
        chk("t5_no_early_fd", n_fd - f0, 0);
        w_inj = n_wr - 1;
        k = 0;
        while (n_fd == f0 && k < 8000) begin rand_step(); k++; end
        chk("t5_fd_timeout", k < 8000, 1);
        chk("t5_frame_writes", n_wr - w_inj, FRAME);
        chk("t5_sof_err_total", n_se - s0, 1);
        bus.enable = 0;
        wait_idle("t5_idle");

        // Test 6: enable dropped mid-burst, then reset during READ
        bus.enable = 1; bus.src_count = 20; bus.dst_count_w = 0;
        k = 0;
        while (!bus.src_rd && k < 20) begin @(negedge clk_w); #1; k++; end
        chk("t6_start", bus.src_rd, 1);
        repeat (2) @(negedge clk_w);
        #1;
        bus.enable = 0;
        rd_n = 3;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_w); #1;
            rd_n += int'(bus.src_rd);
        end
        chk("t6_burst_completes", rd_n, BURST);
        bus.enable = 1;
        k = 0;
        while (!bus.src_rd && k < 20) begin @(negedge clk_w); #1; k++; end
        chk("t6_second_start", bus.src_rd, 1);
        repeat (2) @(negedge clk_w);
        #1;
        chk("t6_locked_before", bus.locked, 1);
        rst_n = 0;
        #1;
        chk("t6_rst_src_rd", bus.src_rd, 0);
        chk("t6_rst_dst_wr", bus.dst_wr, 0);
        chk("t6_rst_locked", bus.locked, 0);
        chk("t6_rst_busy", bus.busy, 0);
        repeat (3) @(negedge clk_w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pixel_burst_scheduler.md
Name: pixel_burst_scheduler

Overview:
Sequences pixel transfer from the camera-side FIFO into the super-resolution output FIFO in fixed-length bursts, all in the clk_w domain. A burst is granted only when the source holds enough pixels and the destination has enough free space. Each pixel is tracked against frame geometry using the bit-16 start-of-frame flag. The block reports frame completion and SOF misalignment.

Parameters:
BURST, 8, pixels per burst (1..64)
MARGIN, 4, extra destination free slots required beyond BURST
FIFO_AW, 10, address width of both FIFOs (depth 2**FIFO_AW)
H_ACTIVE, 320, pixels per line
V_ACTIVE, 240, lines per frame

Ports:
clk_w  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new bursts to start
src_count  in  FIFO_AW  occupancy of the source FIFO, read side
src_rd  out  1  source FIFO read strobe
src_data  in  17  source pixel; bit16 = SOF, bits15:0 = RGB565
dst_count_w  in  FIFO_AW  occupancy of the output FIFO, write side
dst_wr  out  1  output FIFO write strobe
dst_data  out  17  pixel to the output FIFO
locked  out  1  first SOF seen since reset
frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
sof_error  out  1  one-cycle pulse when SOF arrives off position 0,0
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; src_rd=0, dst_wr=0, dst_data=0, locked=0, frame_done=0, sof_error=0, busy=0; x=0, y=0, burst counter=0.
- dst_free = 2**FIFO_AW - dst_count_w, computed (FIFO_AW+1) bits wide with no truncation.
- Grant condition: enable && src_count >= BURST && dst_free >= BURST+MARGIN.
- FSM states:
  - IDLE: when the grant condition is true, go to READ and assert src_rd on the next cycle.
  - READ: src_rd=1 for exactly BURST consecutive cycles (counter 0..BURST-1); after the last cycle go to DRAIN.
  - DRAIN: one cycle with src_rd=0 to capture the last pixel, then return to IDLE.
  - Back-to-back bursts are not allowed: at least one IDLE cycle separates bursts.
- Source latency: src_data is valid the cycle after src_rd. A registered rd_q flags the valid cycle.
- Output latency: dst_wr and dst_data are registered one cycle after the rd_q cycle, so total src_rd-to-dst_wr latency is 2 cycles.
- Disposition of each valid pixel (rd_q=1):
  - Not locked and SOF=0: discard, with no dst_wr.
  - Not locked and SOF=1: set locked, write the pixel, set x=1, y=0.
  - Locked and SOF=1 with (x,y)!=(0,0): pulse sof_error, write the pixel, resync to x=1, y=0.
  - Locked, normal case: write the pixel and advance x. When x=H_ACTIVE-1, x wraps to 0 and y increments. When y=V_ACTIVE-1 and x wraps, y wraps to 0 and frame_done pulses with the dst_wr of that pixel.
  - Locked, SOF=0 at (0,0): write the pixel and count it as the first pixel (no error).
- dst_data is a straight copy of src_data, including bit16.
- enable deasserted mid-burst: the current burst completes in full; no new grant is issued.
- Counts move during a burst: the grant is evaluated only in IDLE. MARGIN covers the 2-cycle write latency and the count synchroniser lag in the FIFOs.
- Simultaneous frame_done and sof_error cannot occur; SOF resync has priority over wrap detection.

Test Plan:
1. Reset with src_count=20, dst_count_w=0, enable=1 -> first src_rd 1 cycle after IDLE grant; 8 src_rd cycles; first dst_wr exactly 2 cycles after the first src_rd; busy high for 9 cycles.
2. src_count=7, or dst_count_w=1013 (free=11 < 12) -> no src_rd. Then dst_count_w=1012 -> burst starts.
3. Feed 3 pixels with SOF=0 before the first SOF -> zero dst_wr and locked=0; the SOF pixel is written and locked=1.
4. Stream a full 320x240 frame -> exactly 76800 dst_wr; frame_done pulses once, coincident with the last write; x,y return to 0,0.
5. Inject SOF at pixel 100 of line 5 -> sof_error one-cycle pulse; the next 76800 pixels produce frame_done at the correct point.
6. Drop enable mid-burst, then assert rst_n=0 during READ -> the burst completes before rst; on reset, src_rd and dst_wr go to 0 immediately and locked clears.
